// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit path: byte width, the default
// clock and baud settings the transmitter is built for, and the state
// encoding of the transmit feeder's launch FSM.
package uart_pkg;

  // Width of one UART character.
  localparam int BYTE_W = 8;

  // Default system clock and line rate shared with the transmitter.
  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD_RATE    = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

  // Feeder launch FSM encoding; kept as plain constants so older blocks
  // that compare against raw 2-bit codes keep working.
  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] LAUNCH    = 2'b01;
  localparam logic [1:0] WAIT_DONE = 2'b10;

  // One character as carried between producer, FIFO and transmitter.
  typedef logic [BYTE_W-1:0] byte_t;

  // True for any of the three encodings the FSM is allowed to hold.
  function automatic logic is_legal_state(input logic [1:0] st);
    logic ok;
    case (st)
      IDLE:      ok = 1'b1;
      LAUNCH:    ok = 1'b1;
      WAIT_DONE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO for the UART transmit feeder.
// Occupancy is kept as a registered count; full/empty are decoded from
// that register only, so a push into a full FIFO is refused even when a
// pop happens in the same cycle. DEPTH must be a power of two so the
// read/write pointers wrap naturally at ADDR_W bits.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] rdata_o,
  output logic [ADDR_W:0]   level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W + 1)'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1'b1);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_d;
  logic              full_s;
  logic              empty_s;
  logic              do_push_s;
  logic              do_pop_s;

  assign full_s    = (level_q == DEPTH_L);
  assign empty_s   = (level_q == {(ADDR_W + 1){1'b0}});
  assign do_push_s = push_i && !full_s;
  assign do_pop_s  = pop_i && !empty_s;

  // Pointer advance and occupancy update; push and pop together cancel.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      level_q  <= {(ADDR_W + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte-buffering feeder in front of the UART transmitter.
// Producers push bytes over valid/ready into a FIFO; a small FSM hands
// them one at a time to the transmitter's data_in/start/busy interface.
// Start is held as a level until the transmitter raises busy; if busy
// never rises within ACK_TIMEOUT cycles the byte is dropped and
// timeout_err pulses for one cycle.
// Build option: define UART_FEED_OVF_EN to get a sticky overflow flag
// (ovf_flag) cleared by ovf_clr; without it ovf_flag is constant 0.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              timeout_err,
  output logic              ovf_flag,
  input  logic              ovf_clr
);

  // Counter must hold 0..ACK_TIMEOUT-1.
  localparam int              CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [BYTE_W-1:0] tx_data_q;
  logic [BYTE_W-1:0] tx_data_d;
  logic              tx_start_q;
  logic              tx_start_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              timeout_q;
  logic              timeout_d;

  logic              push_s;
  logic              pop_s;
  logic [BYTE_W-1:0] fifo_rdata_s;
  logic [ADDR_W:0]   fifo_level_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              wr_ready_s;

  // Acceptance depends only on the registered occupancy.
  assign wr_ready_s = !fifo_full_s;
  assign push_s     = wr_valid && wr_ready_s;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .wdata_i (wr_data),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .level_o (fifo_level_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Launch FSM: pop a byte, hold start until busy, then wait for busy to fall.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && !tx_busy) begin
          pop_s      = 1'b1;
          tx_data_d  = fifo_rdata_s;
          tx_start_d = 1'b1;
          cnt_d      = CNT_ZERO;
          state_d    = LAUNCH;
        end else begin
          tx_start_d = 1'b0;
          state_d    = IDLE;
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never acknowledged: drop this byte.
          tx_start_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else begin
          tx_start_d = 1'b1;
          cnt_d      = cnt_q + CNT_ONE;
          state_d    = LAUNCH;
        end
      end
      WAIT_DONE: begin
        tx_start_d = 1'b0;
        if (!tx_busy) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        // Corrupted encoding: fall back to a quiet IDLE.
        tx_start_d = 1'b0;
        cnt_d      = CNT_ZERO;
        state_d    = IDLE;
      end
    endcase
    if (!is_legal_state(state_d)) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // FSM state, transmitter-facing registers, timeout counter and pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      cnt_q      <= CNT_ZERO;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef UART_FEED_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky overflow: a refused offer sets it and beats a same-cycle clear.
  always_comb begin
    if (wr_valid && !wr_ready_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_flag = ovf_q;
`else
  logic unused_ovf_clr_s;
  assign unused_ovf_clr_s = ovf_clr;
  assign ovf_flag         = 1'b0;
`endif

  assign wr_ready    = wr_ready_s;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign level       = fifo_level_s;
  assign empty       = fifo_empty_s;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a behavioural feeder model
// (byte queue plus launch/ack/timeout bookkeeping) predicts every output
// each cycle, and a transmitter model raises busy two cycles after it
// samples start and records the bytes it receives.
module tb_uart_tx_feeder;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 1024;
  localparam int DRAIN_MAX   = 5000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  logic [ADDR_W:0] level;
  logic            empty;
  logic            timeout_err;
  logic            ovf_flag;
  logic            ovf_clr = 1'b0;

  uart_tx_feeder #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .level       (level),
    .empty       (empty),
    .timeout_err (timeout_err),
    .ovf_flag    (ovf_flag),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Feeder reference model.
  logic [7:0] m_fifo[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_data;
  bit         m_start;
  bit         m_wait;
  bit         m_to;
  bit         m_ovf;
  int         m_hold;

  // Transmitter model.
  logic [7:0] tx_got[$];
  bit         tx_dead;
  int         tx_len_min;
  int         tx_len_max;
  int         tx_arm;
  int         tx_remain;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_data    = 8'h00;
    m_start   = 1'b0;
    m_wait    = 1'b0;
    m_to      = 1'b0;
    m_ovf     = 1'b0;
    m_hold    = 0;
    tx_arm    = 0;
    tx_remain = 0;
    tx_busy   = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("tx_start", 32'(tx_start), 32'(m_start));
    check_val("tx_data", 32'(tx_data), 32'(m_data));
    check_val("level", 32'(level), m_fifo.size());
    check_val("empty", 32'(empty), 32'(m_fifo.size() == 0));
    check_val("wr_ready", 32'(wr_ready), 32'(m_fifo.size() != DEPTH));
    check_val("timeout_err", 32'(timeout_err), 32'(m_to));
    check_val("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
  endtask

  // One clock: check at the falling edge, predict the next state from the
  // inputs the DUT will sample, commit just after the rising edge.
  task automatic cycle();
    bit         full_now, accept, n_start, n_wait, n_to, n_ovf, n_busy;
    logic [7:0] n_data;
    int         n_hold, n_arm, n_remain;
    @(negedge clk);
    check_outputs();
    if (!reset_n) begin
      @(posedge clk);
      #1;
      return;
    end
    full_now = (m_fifo.size() == DEPTH);
    accept   = wr_valid && !full_now;
    n_start  = m_start;
    n_wait   = m_wait;
    n_data   = m_data;
    n_hold   = m_hold;
    n_to     = 1'b0;
    if (m_start) begin
      if (tx_busy) begin
        n_start = 1'b0;
        n_wait  = 1'b1;
        m_sent.push_back(m_data);
      end else if (m_hold == ACK_TIMEOUT - 1) begin
        n_start = 1'b0;
        n_to    = 1'b1;
      end else begin
        n_hold = m_hold + 1;
      end
    end else if (m_wait) begin
      if (!tx_busy) n_wait = 1'b0;
    end else if (m_fifo.size() != 0 && !tx_busy) begin
      n_data  = m_fifo.pop_front();
      n_start = 1'b1;
      n_hold  = 0;
    end
    if (accept) m_fifo.push_back(wr_data);
`ifdef UART_FEED_OVF_EN
    if (wr_valid && full_now) n_ovf = 1'b1;
    else if (ovf_clr) n_ovf = 1'b0;
    else n_ovf = m_ovf;
`else
    n_ovf = 1'b0;
`endif
    // Transmitter: busy two cycles after start is sampled, then random length.
    n_busy   = tx_busy;
    n_arm    = tx_arm;
    n_remain = tx_remain;
    if (!tx_dead) begin
      if (tx_busy) begin
        if (tx_remain <= 1) n_busy = 1'b0;
        else n_remain = tx_remain - 1;
      end else if (tx_arm > 0) begin
        if (tx_arm == 1) begin
          n_busy   = 1'b1;
          n_remain = int'($urandom_range(tx_len_max, tx_len_min));
        end
        n_arm = tx_arm - 1;
      end else if (tx_start) begin
        n_arm = 2;
        tx_got.push_back(tx_data);
      end
    end
    @(posedge clk);
    #1;
    m_start   = n_start;
    m_wait    = n_wait;
    m_data    = n_data;
    m_hold    = n_hold;
    m_to      = n_to;
    m_ovf     = n_ovf;
    tx_busy   = n_busy;
    tx_arm    = n_arm;
    tx_remain = n_remain;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic put(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((m_fifo.size() != 0 || m_start || m_wait || tx_busy || tx_arm != 0) && g < DRAIN_MAX) begin
      cycle();
      g++;
    end
    check_val(tag, 32'(g < DRAIN_MAX), 32'd1);
  endtask

  initial begin
    int peak, hi, to_cnt, n_acc, got_before, guard;
    n_checks   = 0;
    n_fail     = 0;
    tx_dead    = 1'b0;
    tx_len_min = 3;
    tx_len_max = 10;
    model_reset();

    // Reset state.
    run_cycles(3);
    check_val("rst_tx_data", 32'(tx_data), 32'h00);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_val("rst_empty", 32'(empty), 32'd1);
    reset_n = 1'b1;
    run_cycles(2);

    // Single byte: level at N+1, start at N+2.
    put(8'hA5);
    check_val("lat_level_n1", 32'(level), 32'd1);
    check_val("lat_start_n1", 32'(tx_start), 32'd0);
    cycle();
    check_val("lat_start_n2", 32'(tx_start), 32'd1);
    check_val("lat_data_n2", 32'(tx_data), 32'hA5);
    drain("drain_single");

    // Burst of 16 with a slow transmitter.
    tx_len_min = 40;
    tx_len_max = 60;
    peak = 0;
    for (int i = 0; i < 16; i++) begin
      check_val("burst_ready", 32'(wr_ready), 32'd1);
      put(8'(i));
      if (int'(level) > peak) peak = int'(level);
    end
    check_val("burst_peak", 32'(peak == 15 || peak == 16), 32'd1);
    drain("drain_burst");

    // Overfill; refused writes and overflow flag behaviour.
    tx_len_min = 150;
    tx_len_max = 150;
    for (int i = 0; i < 20; i++) put(8'h80 + 8'(i));
    check_val("full_ready", 32'(wr_ready), 32'd0);
    check_val("full_level", 32'(level), 32'd16);
    wr_valid = 1'b1;
    ovf_clr  = 1'b1;
    cycle();
    wr_valid = 1'b0;
`ifdef UART_FEED_OVF_EN
    check_val("ovf_set_wins", 32'(ovf_flag), 32'd1);
`else
    check_val("ovf_tied", 32'(ovf_flag), 32'd0);
`endif
    run_cycles(3);
    cycle();
    ovf_clr = 1'b0;
    check_val("ovf_cleared", 32'(ovf_flag), 32'd0);
    tx_len_min = 3;
    tx_len_max = 10;
    drain("drain_full");

    // Transmitter never acknowledges: one timeout, then next byte goes out.
    tx_dead = 1'b1;
    put(8'h3C);
    put(8'hC3);
    hi     = int'(tx_start);
    to_cnt = 0;
    for (int i = 0; i < ACK_TIMEOUT + 100; i++) begin
      cycle();
      if (tx_start) hi++;
      if (timeout_err) begin
        to_cnt++;
        break;
      end
    end
    tx_dead = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (timeout_err) to_cnt++;
    end
    check_val("timeout_hold", hi, ACK_TIMEOUT);
    check_val("timeout_pulses", to_cnt, 32'd1);
    drain("drain_timeout");

    // Random traffic around level 3 with simultaneous push/pop and wrap.
    tx_len_min = 1;
    tx_len_max = 4;
    n_acc = 0;
    guard = 0;
    while (n_acc < 40 && guard < 3000) begin
      wr_data  = 8'($urandom);
      wr_valid = (m_fifo.size() < 3) ? 1'b1 : ($urandom_range(3, 0) == 0);
      if (wr_valid && m_fifo.size() != DEPTH) n_acc++;
      cycle();
      guard++;
    end
    wr_valid = 1'b0;
    check_val("rand_bound", 32'(guard < 3000), 32'd1);
    drain("drain_rand");

    // Reset mid-byte with five bytes still queued.
    tx_len_min = 300;
    tx_len_max = 300;
    for (int i = 0; i < 6; i++) put(8'h50 + 8'(i));
    run_cycles(3);
    check_val("rst_mid_queued", 32'(level), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_mid_start", 32'(tx_start), 32'd0);
    check_val("rst_mid_level", 32'(level), 32'd0);
    check_val("rst_mid_empty", 32'(empty), 32'd1);
    model_reset();
    got_before = tx_got.size();
    run_cycles(2);
    reset_n = 1'b1;
    run_cycles(60);
    check_val("rst_no_tx", tx_got.size(), got_before);

    // End-to-end byte order at the transmitter.
    check_val("sent_count", tx_got.size(), m_sent.size());
    for (int i = 0; i < tx_got.size() && i < m_sent.size(); i++) begin
      check_val("sent_byte", 32'(tx_got[i]), 32'(m_sent[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
